// File: rtl/rv32_mon_pkg.sv
// Shared types and constants for the RV32 pipeline monitor.
// Optional macro RV32_MON_DISPLAY_EN (used by the top) enables per-error messages.
package rv32_mon_pkg;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAILED = 2'd3
  } mon_state_e;

  localparam int CHK_X0       = 0;
  localparam int CHK_STALL_PC = 1;
  localparam int CHK_MISALIGN = 2;
  localparam int CHK_WDT      = 3;
  localparam int NUM_CHECKS   = 4;

  // Index of the lowest set error bit; the first-error record prefers low indices.
  function automatic logic [1:0] lowest_err(input logic [NUM_CHECKS-1:0] errs);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (errs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rv32_mon_sat_counter.sv
// Saturating error counter; a clear in the same cycle as an increment yields 1.
module rv32_mon_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LP_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Clear first, then count; hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (r_count != LP_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/rv32_pipeline_monitor.sv
// Runtime checker for the RV32IM 5-stage core: x0 corruption, PC motion under
// stall, PC misalignment and retire starvation. Never drives the core.
// Optional macro RV32_MON_DISPLAY_EN: print one line per detected error.
// ARM is a one-cycle arming state in which no check fires.
module rv32_pipeline_monitor
  import rv32_mon_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IALIGN    = 4,
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            x0_val,
  input  logic [XLEN-1:0]            pc,
  input  logic                       stall,
  input  logic                       retire_valid,
  input  logic                       halt,
  input  logic                       clr_err,
  output logic [NUM_CHECKS-1:0]      err_flags,
  output logic [NUM_CHECKS*CNT_W-1:0] err_cnt,
  output logic                       fail,
  output logic [1:0]                 first_err_id,
  output logic [XLEN-1:0]            first_err_pc,
  output logic [1:0]                 mon_state
);

  localparam logic [WDT_W-1:0] LP_WDT_LIMIT = WDT_W'(WDT_LIMIT);

  mon_state_e            r_state;
  mon_state_e            w_state_next;
  logic [XLEN-1:0]       r_prev_pc;
  logic                  r_prev_stall;
  logic                  r_prev_valid;
  logic [WDT_W-1:0]      r_wdt;
  logic [WDT_W-1:0]      w_wdt_next;
  logic [WDT_W-1:0]      w_wdt_inc;
  logic                  w_wdt_count_en;
  logic                  w_wdt_expire;
  logic [NUM_CHECKS-1:0] r_flags;
  logic [NUM_CHECKS-1:0] w_flags_base;
  logic [NUM_CHECKS-1:0] w_flags_next;
  logic [NUM_CHECKS-1:0] w_err;
  logic [1:0]            r_first_id;
  logic [1:0]            w_first_id_next;
  logic [XLEN-1:0]       r_first_pc;
  logic [XLEN-1:0]       w_first_pc_next;
  logic                  w_armed;
  logic                  w_misalign;

  assign w_armed = (r_state != ARM);

  // Alignment test selects the low PC bits that must be zero.
  generate
    if (IALIGN == 2) begin : g_align2
      assign w_misalign = pc[0];
    end else begin : g_align4
      assign w_misalign = |pc[1:0];
    end
  endgenerate

  // Watchdog: advance on starved cycles in RUN/FAILED, reload on expiry or retire.
  always_comb begin
    w_wdt_count_en = (r_state == RUN) || (r_state == FAILED);
    w_wdt_inc      = r_wdt + WDT_W'(1);
    w_wdt_expire   = 1'b0;
    w_wdt_next     = r_wdt;
    if (retire_valid) begin
      w_wdt_next = '0;
    end else if (w_wdt_count_en) begin
      if (w_wdt_inc == LP_WDT_LIMIT) begin
        w_wdt_expire = 1'b1;
        w_wdt_next   = '0;
      end else begin
        w_wdt_next = w_wdt_inc;
      end
    end
  end

  // Per-check error detection for this cycle.
  always_comb begin
    w_err               = '0;
    w_err[CHK_X0]       = w_armed && (x0_val != '0);
    w_err[CHK_STALL_PC] = r_prev_valid && r_prev_stall && (pc != r_prev_pc);
    w_err[CHK_MISALIGN] = w_armed && w_misalign;
    w_err[CHK_WDT]      = w_wdt_expire;
  end

  // Sticky flags and first-error record; a clear lands before this cycle's errors.
  always_comb begin
    w_flags_base    = clr_err ? '0 : r_flags;
    w_flags_next    = w_flags_base | w_err;
    w_first_id_next = clr_err ? 2'd0 : r_first_id;
    w_first_pc_next = clr_err ? '0 : r_first_pc;
    if ((|w_err) && !(|w_flags_base)) begin
      w_first_id_next = lowest_err(w_err);
      w_first_pc_next = pc;
    end
  end

  // Next-state logic for the monitor FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARM:     w_state_next = RUN;
      RUN:     w_state_next = (|w_err) ? FAILED : (halt ? HALTED : RUN);
      HALTED:  w_state_next = (|w_err) ? FAILED : (halt ? HALTED : RUN);
      FAILED:  w_state_next = (clr_err && !(|w_err)) ? RUN : FAILED;
      default: w_state_next = ARM;
    endcase
  end

  // Register state, history, watchdog and error record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARM;
      r_prev_pc    <= '0;
      r_prev_stall <= 1'b0;
      r_prev_valid <= 1'b0;
      r_wdt        <= '0;
      r_flags      <= '0;
      r_first_id   <= 2'd0;
      r_first_pc   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_prev_pc    <= pc;
      r_prev_stall <= stall;
      r_prev_valid <= w_armed;
      r_wdt        <= w_wdt_next;
      r_flags      <= w_flags_next;
      r_first_id   <= w_first_id_next;
      r_first_pc   <= w_first_pc_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cnt
      rv32_mon_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err[gi]),
        .clr   (clr_err),
        .count (err_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

`ifdef RV32_MON_DISPLAY_EN
  // Report each detected error as it is sampled.
  always @(posedge clk) begin
    if (!rst) begin
      if (w_err[CHK_X0])
        $display("%0t rv32_mon x0 pc=%h x0_val=%h", $time, pc, x0_val);
      if (w_err[CHK_STALL_PC])
        $display("%0t rv32_mon stall_pc pc=%h prev_pc=%h", $time, pc, r_prev_pc);
      if (w_err[CHK_MISALIGN])
        $display("%0t rv32_mon misalign pc=%h", $time, pc);
      if (w_err[CHK_WDT])
        $display("%0t rv32_mon watchdog pc=%h starved=%0d", $time, pc, WDT_LIMIT);
    end
  end
`else
  // Silent build: behaviour of flags and counters is unchanged.
`endif

  assign err_flags    = r_flags;
  assign fail         = |r_flags;
  assign first_err_id = r_first_id;
  assign first_err_pc = r_first_pc;
  assign mon_state    = r_state;

endmodule

// File: tb/tb_rv32_pipeline_monitor.sv
// Bench: two monitors (IALIGN 4 and 2) share stimulus; a behavioural model
// per instance is compared every cycle, with literal expectations per phase.
module tb_rv32_pipeline_monitor;

  localparam int WDT   = 8;
  localparam int CW    = 8;
  localparam int S_ARM = 0, S_RUN = 1, S_HALTED = 2, S_FAILED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] x0_val = '0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        retire_valid = 1'b0;
  logic        halt = 1'b0;
  logic        clr_err = 1'b0;

  logic [3:0]  a_flags, b_flags;
  logic [31:0] a_cnt, b_cnt;
  logic        a_fail, b_fail;
  logic [1:0]  a_fid, b_fid;
  logic [31:0] a_fpc, b_fpc;
  logic [1:0]  a_st, b_st;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  rv32_pipeline_monitor #(.XLEN(32), .IALIGN(4), .WDT_LIMIT(WDT), .WDT_W(16), .CNT_W(CW)) u_dut_a (
    .clk(clk), .rst(rst), .x0_val(x0_val), .pc(pc), .stall(stall),
    .retire_valid(retire_valid), .halt(halt), .clr_err(clr_err),
    .err_flags(a_flags), .err_cnt(a_cnt), .fail(a_fail),
    .first_err_id(a_fid), .first_err_pc(a_fpc), .mon_state(a_st));

  rv32_pipeline_monitor #(.XLEN(32), .IALIGN(2), .WDT_LIMIT(WDT), .WDT_W(16), .CNT_W(CW)) u_dut_b (
    .clk(clk), .rst(rst), .x0_val(x0_val), .pc(pc), .stall(stall),
    .retire_valid(retire_valid), .halt(halt), .clr_err(clr_err),
    .err_flags(b_flags), .err_cnt(b_cnt), .fail(b_fail),
    .first_err_id(b_fid), .first_err_pc(b_fpc), .mon_state(b_st));

  always #5 clk = ~clk;

  // Behavioural model, one copy per instance (0: IALIGN 4, 1: IALIGN 2).
  int          m_ialign [2] = '{4, 2};
  int          m_st     [2];
  bit [3:0]    m_flags  [2];
  int          m_cnt    [2][4];
  int          m_fid    [2];
  logic [31:0] m_fpc    [2];
  int          m_wdt    [2];
  logic [31:0] m_ppc    [2];
  bit          m_ps     [2];
  bit          m_pv     [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_ARM; m_flags[k] = '0; m_fid[k] = 0; m_fpc[k] = '0;
      m_wdt[k] = 0; m_ppc[k] = '0; m_ps[k] = 1'b0; m_pv[k] = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    end
  endtask

  // One rising edge of the monitor as described by the rules, in plain arithmetic.
  task automatic model_step(input int k);
    bit [3:0] e;
    bit armed;
    e = '0;
    armed = (m_st[k] != S_ARM);
    if (armed && x0_val != 0) e[0] = 1'b1;
    if (m_pv[k] && m_ps[k] && pc != m_ppc[k]) e[1] = 1'b1;
    if (armed && (pc % m_ialign[k]) != 0) e[2] = 1'b1;
    if (retire_valid) m_wdt[k] = 0;
    else if (m_st[k] == S_RUN || m_st[k] == S_FAILED) begin
      m_wdt[k]++;
      if (m_wdt[k] == WDT) begin e[3] = 1'b1; m_wdt[k] = 0; end
    end
    if (clr_err) begin
      m_flags[k] = '0; m_fid[k] = 0; m_fpc[k] = '0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (e[i] && m_cnt[k][i] < 255) m_cnt[k][i]++;
    if (e != 0 && m_flags[k] == 0) begin
      m_fpc[k] = pc;
      for (int i = 3; i >= 0; i--) if (e[i]) m_fid[k] = i;
    end
    m_flags[k] = m_flags[k] | e;
    case (m_st[k])
      S_ARM:    m_st[k] = S_RUN;
      S_FAILED: m_st[k] = (clr_err && e == 0) ? S_RUN : S_FAILED;
      default:  m_st[k] = (e != 0) ? S_FAILED : (halt ? S_HALTED : S_RUN);
    endcase
    m_pv[k] = armed; m_ppc[k] = pc; m_ps[k] = stall;
  endtask

  function automatic logic [31:0] exp_cnt(input int k);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(m_cnt[k][i]);
    return v;
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_flags", a_flags, m_flags[0]); chk("b_flags", b_flags, m_flags[1]);
      chk("a_cnt", a_cnt, exp_cnt(0));     chk("b_cnt", b_cnt, exp_cnt(1));
      chk("a_fail", a_fail, m_flags[0] != 0); chk("b_fail", b_fail, m_flags[1] != 0);
      chk("a_fid", a_fid, m_fid[0]);       chk("b_fid", b_fid, m_fid[1]);
      chk("a_fpc", a_fpc, m_fpc[0]);       chk("b_fpc", b_fpc, m_fpc[1]);
      chk("a_state", a_st, m_st[0]);       chk("b_state", b_st, m_st[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst) begin model_step(0); model_step(1); end
    #1;
  endtask

  task automatic drive(input logic [31:0] x0, input logic [31:0] p, input bit st,
                       input bit rt, input bit hl, input bit cl);
    x0_val = x0; pc = p; stall = st; retire_valid = rt; halt = hl; clr_err = cl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] cur_pc;
    int burst;
    #1 rst = 1'b1;
    model_reset();
    #2 cmp_en = 1'b1;
    chk("rst_state", a_st, 2'd0); chk("rst_flags", a_flags, 4'd0);
    chk("rst_cnt", a_cnt, 32'd0); chk("rst_fpc", a_fpc, 32'd0);
    tick();
    rst = 1'b0;

    $display("phase: clean run");
    drive(0, 32'h0, 0, 1, 0, 0); tick();
    chk("run_after_arm", a_st, 2'd1);
    drive(0, 32'h4, 0, 1, 0, 0); tick();
    drive(0, 32'h8, 0, 1, 0, 0); tick();
    chk("clean_fail", a_fail, 1'b0); chk("clean_cnt", a_cnt, 32'd0);

    $display("phase: x0 corruption");
    drive(1, 32'hC, 0, 1, 0, 0); tick();
    drive(1, 32'h10, 0, 1, 0, 0); tick();
    drive(1, 32'h14, 0, 1, 0, 0); tick();
    chk("x0_flags", a_flags, 4'b0001); chk("x0_cnt0", a_cnt[7:0], 8'd3);
    chk("x0_fid", a_fid, 2'd0); chk("x0_fpc", a_fpc, 32'hC); chk("x0_state", a_st, 2'd3);
    drive(0, 32'h18, 0, 1, 0, 1); tick();
    chk("clr_flags", a_flags, 4'd0); chk("clr_state", a_st, 2'd1);

    $display("phase: stall pc");
    drive(0, 32'h100, 1, 1, 0, 0); tick();
    drive(0, 32'h104, 0, 1, 0, 0); tick();
    chk("stall_flags", a_flags, 4'b0010); chk("stall_fpc", a_fpc, 32'h104);
    drive(0, 32'h108, 0, 1, 0, 1); tick();
    do_reset();
    drive(0, 32'h100, 1, 1, 0, 0); tick();
    drive(0, 32'h104, 0, 1, 0, 0); tick();
    chk("stall_post_reset", a_flags, 4'd0);

    $display("phase: misalign");
    drive(0, 32'h102, 0, 1, 0, 0); tick();
    chk("mis4_flags", a_flags, 4'b0100); chk("mis2_flags", b_flags, 4'd0);
    drive(0, 32'h104, 0, 1, 0, 1); tick();
    drive(5, 32'h101, 0, 1, 0, 0); tick();
    chk("mis_x0_flags", a_flags, 4'b0101); chk("mis_x0_fid", a_fid, 2'd0);
    chk("mis_x0_b", b_flags, 4'b0101);
    drive(0, 32'h108, 0, 1, 0, 1); tick();

    $display("phase: watchdog");
    drive(0, 32'h10C, 0, 1, 0, 0); tick();
    drive(0, 32'h10C, 0, 0, 0, 0);
    for (int i = 0; i < WDT - 1; i++) tick();
    chk("wdt_early", a_flags[3], 1'b0);
    tick();
    chk("wdt_fire", a_flags, 4'b1000); chk("wdt_cnt1", a_cnt[31:24], 8'd1);
    chk("wdt_fid", a_fid, 2'd3);
    for (int i = 0; i < WDT; i++) tick();
    chk("wdt_cnt2", a_cnt[31:24], 8'd2);
    drive(0, 32'h10C, 0, 1, 0, 1); tick();

    $display("phase: halt freezes watchdog");
    drive(0, 32'h110, 0, 1, 0, 0); tick();
    drive(0, 32'h110, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    drive(0, 32'h110, 0, 0, 1, 0);
    for (int i = 0; i < 21; i++) tick();
    chk("halt_flags", a_flags, 4'd0); chk("halt_state", a_st, 2'd2);
    drive(0, 32'h110, 0, 1, 0, 0); tick();
    chk("unhalt_state", a_st, 2'd1);

    $display("phase: counter saturation and clear");
    drive(1, 32'h200, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt0", a_cnt[7:0], 8'd255); chk("sat_fpc", a_fpc, 32'h200);
    drive(0, 32'h200, 0, 1, 0, 1); tick();
    chk("clr_all_flags", a_flags, 4'd0); chk("clr_all_cnt", a_cnt, 32'd0);
    chk("clr_all_state", a_st, 2'd1); chk("clr_all_fpc", a_fpc, 32'd0);
    drive(1, 32'h200, 0, 1, 0, 1); tick();
    chk("clr_err_flags", a_flags, 4'b0001); chk("clr_err_cnt", a_cnt, 32'd1);
    chk("clr_err_state", a_st, 2'd3);

    $display("phase: asynchronous reset");
    drive(1, 32'h204, 0, 1, 0, 0); tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_state", a_st, 2'd0); chk("async_flags", a_flags, 4'd0);
    chk("async_cnt", a_cnt, 32'd0);
    drive(0, 32'h0, 0, 1, 0, 0); tick();
    rst = 1'b0;

    $display("phase: random");
    cur_pc = 32'h1000;
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(999) < 3) begin
        rst = 1'b1; model_reset(); tick(); rst = 1'b0;
      end
      x0_val = ($urandom_range(99) < 3) ? $urandom : 32'd0;
      if (!(stall && $urandom_range(9) != 0)) begin
        case ($urandom_range(99))
          0, 1:    cur_pc = cur_pc + 32'($urandom_range(1, 3));
          2, 3:    cur_pc = $urandom & 32'h0000_FFFC;
          default: cur_pc = cur_pc + 32'd4;
        endcase
      end
      pc = cur_pc;
      stall = ($urandom_range(99) < 25);
      if (burst == 0 && $urandom_range(99) < 2) burst = $urandom_range(5, 20);
      if (burst > 0) begin retire_valid = 1'b0; burst--; end
      else retire_valid = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 4) halt = ~halt;
      clr_err = ($urandom_range(99) < 3);
      tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
